// File: rtl/decode_queue_pkg.sv
// Shared types and instruction-field helpers for the decode queue.
// Field extraction and branch/jump target arithmetic live here so every user decodes the same way.
package decode_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic        exc_miss;
        logic [4:0]  exccode;
    } q_entry_t;

    function automatic logic [4:0] get_rs(input logic [31:0] inst);
        return inst[25:21];
    endfunction

    function automatic logic [4:0] get_rt(input logic [31:0] inst);
        return inst[20:16];
    endfunction

    function automatic logic [15:0] get_imm(input logic [31:0] inst);
        return inst[15:0];
    endfunction

    function automatic logic [25:0] get_index(input logic [31:0] inst);
        return inst[25:0];
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] inst);
        logic [15:0] imm;
        imm = get_imm(inst);
        return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] pc_plus4;
        pc_plus4 = pc + 32'd4;
        return {pc_plus4[31:28], get_index(inst), 2'b00};
    endfunction

endpackage

// File: rtl/decode_queue_fwd_select.sv
// Per-operand forwarding mux: the lowest-index matching channel wins and stalls if its result is not ready.
// Register 0 never matches, so a zero destination address means "no write".
module fwd_select #(
    parameter int NFWD = 2
) (
    input  logic [4:0]         raddr,
    input  logic [31:0]        rf_rdata,
    input  logic [5*NFWD-1:0]  fwd_addr,
    input  logic [32*NFWD-1:0] fwd_data,
    input  logic [NFWD-1:0]    fwd_ok,
    output logic [31:0]        data,
    output logic               stall
);

    logic [NFWD-1:0] w_hit;

    for (genvar gi = 0; gi < NFWD; gi++) begin : g_hit
        assign w_hit[gi] = (raddr != 5'd0) && (raddr == fwd_addr[gi*5 +: 5]);
    end

    // Walk from lowest priority upward so the youngest producer overwrites older ones.
    always_comb begin
        data  = rf_rdata;
        stall = 1'b0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                data  = fwd_data[k*32 +: 32];
                stall = !fwd_ok[k];
            end
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Circular decode queue: buffers fetched instructions, resolves head operands through forwarding,
// and registers the decoded result toward execute.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NFWD  = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    input  logic                       in_exc,
    input  logic                       in_exc_miss,
    input  logic [4:0]                 in_exccode,
    input  logic                       flush_i,
    output logic [4:0]                 rf_raddr1,
    output logic [4:0]                 rf_raddr2,
    input  logic [31:0]                rf_rdata1,
    input  logic [31:0]                rf_rdata2,
    input  logic [5*NFWD-1:0]          fwd_addr,
    input  logic [32*NFWD-1:0]         fwd_data,
    input  logic [NFWD-1:0]            fwd_ok,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_rdata1,
    output logic [31:0]                out_rdata2,
    output logic [31:0]                out_pc_j,
    output logic [31:0]                out_pc_b,
    output logic                       out_exc,
    output logic                       out_exc_miss,
    output logic [4:0]                 out_exccode,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                perfcnt_fwd_stall,
    output logic [31:0]                perfcnt_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    q_entry_t      r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_out_valid;
    q_entry_t      r_out;
    logic [31:0]   r_out_rdata1, r_out_rdata2, r_out_pc_j, r_out_pc_b;
    logic [31:0]   r_perf_stall, r_perf_empty;

    q_entry_t    w_head;
    logic        w_empty, w_load, w_push, w_pop, w_stall_head;
    logic        w_stall1, w_stall2;
    logic [31:0] w_data1, w_data2;

    assign w_head    = r_mem[r_head];
    assign w_empty   = (r_count == '0);
    assign in_ready  = (r_count != CW'(DEPTH));
    assign rf_raddr1 = w_empty ? 5'd0 : get_rs(w_head.inst);
    assign rf_raddr2 = w_empty ? 5'd0 : get_rt(w_head.inst);

    fwd_select #(.NFWD(NFWD)) u_fwd_rs (
        .raddr    (rf_raddr1),
        .rf_rdata (rf_rdata1),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .fwd_ok   (fwd_ok),
        .data     (w_data1),
        .stall    (w_stall1)
    );

    fwd_select #(.NFWD(NFWD)) u_fwd_rt (
        .raddr    (rf_raddr2),
        .rf_rdata (rf_rdata2),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .fwd_ok   (fwd_ok),
        .data     (w_data2),
        .stall    (w_stall2)
    );

    // Faulting entries carry no meaningful operands, so they are never held for forwarding.
    assign w_stall_head = (w_stall1 || w_stall2) && !w_head.exc;
    assign w_load       = !r_out_valid || out_ready;
    assign w_push       = in_valid && in_ready && !flush_i;
    assign w_pop        = w_load && !w_empty && !w_stall_head && !flush_i;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= '{pc: in_pc, inst: in_inst, exc: in_exc,
                               exc_miss: in_exc_miss, exccode: in_exccode};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_out_rdata1 <= '0;
            r_out_rdata2 <= '0;
            r_out_pc_j   <= '0;
            r_out_pc_b   <= '0;
            r_perf_stall <= '0;
            r_perf_empty <= '0;
        end else begin
            if (flush_i) begin
                r_head      <= '0;
                r_tail      <= '0;
                r_count     <= '0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_push) r_tail <= r_tail + PW'(1);
                if (w_pop)  r_head <= r_head + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_load) r_out_valid <= w_pop;
            end
            if (w_pop) begin
                r_out        <= w_head;
                r_out_rdata1 <= w_data1;
                r_out_rdata2 <= w_data2;
                r_out_pc_b   <= branch_target(w_head.pc, w_head.inst);
                r_out_pc_j   <= jump_target(w_head.pc, w_head.inst);
            end
            if (!w_empty && w_load && w_stall_head) r_perf_stall <= r_perf_stall + 32'd1;
            if (w_empty && w_load)                  r_perf_empty <= r_perf_empty + 32'd1;
        end
    end

    assign count             = r_count;
    assign out_valid         = r_out_valid;
    assign out_pc            = r_out.pc;
    assign out_inst          = r_out.inst;
    assign out_exc           = r_out.exc;
    assign out_exc_miss      = r_out.exc_miss;
    assign out_exccode       = r_out.exccode;
    assign out_rdata1        = r_out_rdata1;
    assign out_rdata2        = r_out_rdata2;
    assign out_pc_j          = r_out_pc_j;
    assign out_pc_b          = r_out_pc_b;
    assign perfcnt_fwd_stall = r_perf_stall;
    assign perfcnt_empty     = r_perf_empty;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=4, NFWD=2) with hand-computed expectations.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        resetn, in_valid, in_ready, in_exc, in_exc_miss, flush_i;
    logic [31:0] in_pc, in_inst;
    logic [4:0]  in_exccode, rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_ok;
    logic        out_valid, out_ready, out_exc, out_exc_miss;
    logic [31:0] out_pc, out_inst, out_rdata1, out_rdata2, out_pc_j, out_pc_b;
    logic [4:0]  out_exccode;
    logic [2:0]  count;
    logic [31:0] perfcnt_fwd_stall, perfcnt_empty;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Register file stand-in: data encodes the register number.
    assign rf_rdata1 = 32'hAA00_0000 | {27'd0, rf_raddr1};
    assign rf_rdata2 = 32'hBB00_0000 | {27'd0, rf_raddr2};

    decode_queue #(.DEPTH(4), .NFWD(2)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_exc(in_exc), .in_exc_miss(in_exc_miss),
        .in_exccode(in_exccode), .flush_i(flush_i),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_ok(fwd_ok),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rdata1(out_rdata1), .out_rdata2(out_rdata2), .out_pc_j(out_pc_j), .out_pc_b(out_pc_b),
        .out_exc(out_exc), .out_exc_miss(out_exc_miss), .out_exccode(out_exccode),
        .count(count), .perfcnt_fwd_stall(perfcnt_fwd_stall), .perfcnt_empty(perfcnt_empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state got count=%0d out_valid=%b in_ready=%b exp 0/0/1", count, out_valid, in_ready);
        end
        vectors++;
        if (perfcnt_fwd_stall !== 32'd0 || perfcnt_empty !== 32'd0 || out_pc !== 32'd0 || rf_raddr1 !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_regs got stall=%0d empty=%0d out_pc=%h raddr1=%0d exp all 0",
                     perfcnt_fwd_stall, perfcnt_empty, out_pc, rf_raddr1);
        end
        resetn = 1'b1;
        tick();
        vectors++;
        if (perfcnt_empty !== 32'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release got empty=%0d out_valid=%b in_ready=%b exp 1/0/1", perfcnt_empty, out_valid, in_ready);
        end
    endtask

    task automatic test_fill();
        int exp_cnt[5] = '{1, 1, 2, 3, 4};
        out_ready = 1'b0;
        // The first entry drains into the output stage, so five pushes leave four queued.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'hBFC0_0000 + 32'(4 * i);
            in_inst  = 32'h2401_0000 + 32'(i);
            tick();
            vectors++;
            if (count !== 3'(exp_cnt[i])) begin
                miscompares++;
                $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, exp_cnt[i]);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'hBFC0_0000) begin
            miscompares++;
            $display("FAIL fill_full got in_ready=%b out_valid=%b out_pc=%h exp 0/1/bfc00000", in_ready, out_valid, out_pc);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 32'hBFC0_0000 + 32'(4 * i)) begin
                miscompares++;
                $display("FAIL drain_order[%0d] got valid=%b pc=%h exp 1/%h", i, out_valid, out_pc, 32'hBFC0_0000 + 32'(4 * i));
            end
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_empty got valid=%b count=%0d in_ready=%b exp 0/0/1", out_valid, count, in_ready);
        end
    endtask

    task automatic test_fwd_stall();
        fwd_addr = {5'd5, 5'd5};
        fwd_data = {32'h0000_DEAD, 32'h0000_1234};
        fwd_ok   = 2'b10;
        in_valid = 1'b1;
        in_pc    = 32'h8000_0100;
        in_inst  = 32'h00A0_1821;   // addu $3,$5,$0
        tick();
        in_valid = 1'b0;
        vectors++;
        if (count !== 3'd1 || rf_raddr1 !== 5'd5) begin
            miscompares++;
            $display("FAIL fwd_head got count=%0d raddr1=%0d exp 1/5", count, rf_raddr1);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || perfcnt_fwd_stall !== 32'd1) begin
            miscompares++;
            $display("FAIL fwd_stall1 got valid=%b perf=%0d exp 0/1", out_valid, perfcnt_fwd_stall);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || perfcnt_fwd_stall !== 32'd2 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL fwd_stall2 got valid=%b perf=%0d count=%0d exp 0/2/1", out_valid, perfcnt_fwd_stall, count);
        end
        fwd_ok = 2'b11;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_rdata1 !== 32'h0000_1234 || out_rdata2 !== 32'hBB00_0000) begin
            miscompares++;
            $display("FAIL fwd_release got valid=%b rd1=%h rd2=%h exp 1/00001234/bb000000", out_valid, out_rdata1, out_rdata2);
        end
        vectors++;
        if (perfcnt_fwd_stall !== 32'd2 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL fwd_release_cnt got perf=%0d count=%0d exp 2/0", perfcnt_fwd_stall, count);
        end
        fwd_addr = '0; fwd_data = '0; fwd_ok = '0;
        tick();
    endtask

    task automatic test_r0_and_rt();
        fwd_addr = {5'd2, 5'd0};
        fwd_data = {32'h0000_5555, 32'h0000_FFFF};
        fwd_ok   = 2'b10;
        in_valid = 1'b1;
        in_pc    = 32'h8000_0200;
        in_inst  = 32'h2402_0007;   // addiu $2,$0,7
        tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_rdata1 !== 32'hAA00_0000 || out_rdata2 !== 32'h0000_5555) begin
            miscompares++;
            $display("FAIL r0_rt got valid=%b rd1=%h rd2=%h exp 1/aa000000/00005555", out_valid, out_rdata1, out_rdata2);
        end
        fwd_addr = '0; fwd_data = '0; fwd_ok = '0;
        tick();
    endtask

    task automatic test_flush();
        int exp_cnt[4] = '{1, 1, 2, 3};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h8000_1000 + 32'(4 * i);
            in_inst  = 32'h2401_0000;
            tick();
            vectors++;
            if (count !== 3'(exp_cnt[i])) begin
                miscompares++;
                $display("FAIL flush_fill[%0d] got %0d exp %0d", i, count, exp_cnt[i]);
            end
        end
        flush_i = 1'b1;
        in_pc   = 32'hDEAD_0000;
        tick();
        flush_i  = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_now got count=%0d valid=%b exp 0/0", count, out_valid);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 || rf_raddr1 !== 5'd0) begin
            miscompares++;
            $display("FAIL flush_after got count=%0d valid=%b raddr1=%0d exp 0/0/0", count, out_valid, rf_raddr1);
        end
    endtask

    task automatic test_exc();
        fwd_addr   = {5'd0, 5'd5};
        fwd_ok     = 2'b00;
        in_valid   = 1'b1;
        in_pc      = 32'h8000_0300;
        in_inst    = 32'h00A0_1821;
        in_exc     = 1'b1;
        in_exc_miss = 1'b1;
        in_exccode = 5'd4;
        tick();
        in_valid = 1'b0; in_exc = 1'b0; in_exc_miss = 1'b0; in_exccode = 5'd0;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_exc !== 1'b1 || out_exccode !== 5'd4 || out_exc_miss !== 1'b1) begin
            miscompares++;
            $display("FAIL exc_issue got valid=%b exc=%b code=%0d miss=%b exp 1/1/4/1", out_valid, out_exc, out_exccode, out_exc_miss);
        end
        vectors++;
        if (out_pc !== 32'h8000_0300 || perfcnt_fwd_stall !== 32'd2) begin
            miscompares++;
            $display("FAIL exc_nostall got pc=%h perf=%0d exp 80000300/2", out_pc, perfcnt_fwd_stall);
        end
        fwd_addr = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        in_pc    = 32'h8000_FFFC;
        in_inst  = 32'h1000_FFFF;   // beq $0,$0,-1
        tick();
        in_pc    = 32'h8000_0000;
        in_inst  = 32'h0800_0010;   // j 0x10
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_pc_b !== 32'h8000_FFFC || out_pc_j !== 32'h8003_FFFC) begin
            miscompares++;
            $display("FAIL branch_tgt got valid=%b pc_b=%h pc_j=%h exp 1/8000fffc/8003fffc", out_valid, out_pc_b, out_pc_j);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 || out_pc_j !== 32'h8000_0040) begin
            miscompares++;
            $display("FAIL jump_tgt got valid=%b pc=%h pc_j=%h exp 1/80000000/80000040", out_valid, out_pc, out_pc_j);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h8000_0400;
        in_inst   = 32'h2401_0000;
        tick();
        tick();
        in_valid = 1'b0;
        resetn   = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || perfcnt_fwd_stall !== 32'd0 || perfcnt_empty !== 32'd1) begin
            miscompares++;
            $display("FAIL reset_mid got count=%0d valid=%b in_ready=%b stall=%0d empty=%0d exp 0/0/1/0/1",
                     count, out_valid, in_ready, perfcnt_fwd_stall, perfcnt_empty);
        end
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        in_exc = 1'b0; in_exc_miss = 1'b0; in_exccode = '0; flush_i = 1'b0;
        fwd_addr = '0; fwd_data = '0; fwd_ok = '0; out_ready = 1'b0;
        test_reset();
        test_fill();
        test_fwd_stall();
        test_r0_and_rt();
        test_flush();
        test_exc();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
